// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter using the shift-and-add-3 (double dabble) method.
// Converts one WIDTH-bit operand per handshake, WIDTH shift cycles per operand.
module bin2bcd_serial #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic [1:0]            state_dbg_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  // True when DIGITS decimal digits can represent the largest WIDTH-bit value.
  function automatic bit digits_fit();
    longint unsigned cap;
    longint unsigned maxv;
    cap  = 1;
    maxv = (64'd1 << WIDTH) - 64'd1;
    for (int i = 0; i < DIGITS; i++) begin
      cap = cap * 10;
    end
    return (cap > maxv);
  endfunction

  localparam bit FITS = digits_fit();

  if (!FITS) begin : g_bad_digits
    $error("bin2bcd_serial: DIGITS too small for WIDTH");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready only in IDLE, out_valid only in HOLD (never both).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     adj;
  logic [BW-1:0]     scratch_shift;

  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                    : scratch_q[4*i +: 4];
    end
    scratch_shift = {adj[BW-2:0], shift_q[WIDTH-1]};
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = scratch_shift;
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q + 1'b1;
        // Last iteration: capture the post-shift digits directly into bcd.
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = scratch_shift;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q == SHIFT);
  assign out_valid   = (state_q == HOLD);
  assign bcd         = bcd_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial: directed cases, back-pressure,
// reset abort, random operands and an exhaustive sweep against a decimal model.
module tb_bin2bcd_serial;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  bin;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     bcd;
  logic              busy;
  logic [1:0]        state_dbg;

  int checks;
  int errors;

  bin2bcd_serial #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bin         (bin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .bcd         (bcd),
    .busy        (busy),
    .state_dbg_o (state_dbg)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: peel off base-10 digits arithmetically.
  function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full conversion: accept, WIDTH shift cycles, optional stall, handshake.
  task automatic run(input int unsigned v, input int stall, input bit hold_valid);
    logic [BW-1:0] exp;
    exp = ref_bcd(v);
    @(negedge clk);
    check("accept_ready", 32'(in_ready), 32'd1);
    bin       = WIDTH'(v);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    bin = WIDTH'($urandom);
    check("shift_busy", 32'(busy), 32'd1);
    check("shift_not_ready", 32'(in_ready), 32'd0);
    for (int k = 1; k < WIDTH; k++) begin
      @(negedge clk);
      if (hold_valid) bin = WIDTH'($urandom);
      check("early_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    if (hold_valid) bin = WIDTH'($urandom);
    check("valid_at_latency", 32'(out_valid), 32'd1);
    check("result", 32'(bcd), 32'(exp));
    check("hold_not_busy", 32'(busy), 32'd0);
    check("hold_not_ready", 32'(in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_stable", 32'(bcd), 32'(exp));
      check("stall_not_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid_low", 32'(out_valid), 32'd0);
    check("post_idle_ready", 32'(in_ready), 32'd1);
    check("post_no_reaccept", 32'(busy), 32'd0);
    check("post_bcd_kept", 32'(bcd), 32'(exp));
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bin       = '0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed values and back-pressure
    run(0, 0, 1'b0);
    run(255, 0, 1'b0);
    run(99, 0, 1'b0);
    run(100, 0, 1'b0);
    run(9, 0, 1'b0);
    run(173, 5, 1'b0);

    // in_valid held high with a changing operand through SHIFT and HOLD
    run(77, 2, 1'b1);

    // Reset abort partway through a conversion of 200
    @(negedge clk);
    bin       = 8'd200;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    out_ready = 1'b0;
    run(42, 0, 1'b0);

    // Random operands with random stalls
    for (int i = 0; i < 20; i++) begin
      run($urandom_range(0, 255), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      run(v, $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
